// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file issue/writeback scheduler.
// Register index type, control FSM states and a small index helper.
package rf_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } ctrl_state_t;

   function automatic logic nz(input reg_idx_t idx);
      return idx != '0;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard and outstanding-write counter.
// Also latches a sticky error on writeback to a register that is not busy.
module rf_scoreboard #(
   parameter int NREG    = rf_pkg::NREG,
   parameter int MAX_OUT = 4
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_set_en,
   input  logic [rf_pkg::REG_AW-1:0]    i_set_rd,
   input  logic                         i_wb_valid,
   input  logic [rf_pkg::REG_AW-1:0]    i_wb_rd,
   output logic [NREG-1:0]              o_wb_clr,
   output logic [NREG-1:0]              o_busy_mask,
   output logic [rf_pkg::CNT_W-1:0]     o_out_cnt,
   output logic [rf_pkg::CNT_W-1:0]     o_cnt_next,
   output logic                         o_wb_err
);

   import rf_pkg::*;

   logic [NREG-1:0]  r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   logic [NREG-1:0]  w_wb_clr;
   logic [NREG-1:0]  w_set;
   logic [NREG-1:0]  w_busy_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_wb_hit;
   logic             w_busy_hit;
   logic             w_dec;

   assign w_wb_hit   = i_wb_valid & nz(i_wb_rd);
   assign w_busy_hit = r_busy[i_wb_rd];
   assign w_dec      = w_wb_hit & w_busy_hit;

   assign w_wb_clr = w_wb_hit ? (NREG'(1) << i_wb_rd) : '0;
   assign w_set    = (i_set_en & nz(i_set_rd)) ? (NREG'(1) << i_set_rd) : '0;

   // Set is applied after clear so a same-cycle retire/reissue stays busy.
   assign w_busy_next = ((r_busy & ~w_wb_clr) | w_set) & ~NREG'(1);

   assign w_cnt_next = r_cnt + CNT_W'(i_set_en) - CNT_W'(w_dec);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         r_cnt  <= w_cnt_next;
         if (w_wb_hit & ~w_busy_hit) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_wb_clr    = w_wb_clr;
   assign o_busy_mask = r_busy;
   assign o_out_cnt   = r_cnt;
   assign o_cnt_next  = w_cnt_next;
   assign o_wb_err    = r_err;

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Issue/writeback scheduler for the RV32I register file: RAW/WAW stalls,
// same-cycle writeback forwarding, RF port control and a drain handshake.
module rf_hazard_ctrl #(
   parameter int XLEN    = rf_pkg::XLEN,
   parameter int NREG    = rf_pkg::NREG,
   parameter int MAX_OUT = 4
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_issue_valid,
   output logic                         o_issue_ready,
   input  logic [rf_pkg::REG_AW-1:0]    i_issue_rs1,
   input  logic [rf_pkg::REG_AW-1:0]    i_issue_rs2,
   input  logic                         i_issue_use_rs1,
   input  logic                         i_issue_use_rs2,
   input  logic [rf_pkg::REG_AW-1:0]    i_issue_rd,
   input  logic                         i_issue_wr,
   input  logic                         i_wb_valid,
   input  logic [rf_pkg::REG_AW-1:0]    i_wb_rd,
   input  logic [XLEN-1:0]              i_wb_data,
   input  logic                         i_flush_req,
   output logic                         o_flush_done,
   output logic                         o_rf_re1,
   output logic                         o_rf_re2,
   output logic [rf_pkg::REG_AW-1:0]    o_rf_ra1,
   output logic [rf_pkg::REG_AW-1:0]    o_rf_ra2,
   output logic                         o_rf_we,
   output logic [rf_pkg::REG_AW-1:0]    o_rf_wa,
   output logic [XLEN-1:0]              o_rf_wdata,
   output logic                         o_fwd1,
   output logic                         o_fwd2,
   output logic [NREG-1:0]              o_busy_mask,
   output logic [rf_pkg::CNT_W-1:0]     o_out_cnt,
   output logic                         o_wb_err
);

   import rf_pkg::*;

   ctrl_state_t      r_state;
   ctrl_state_t      w_state_next;
   logic             w_flush_done;

   logic [NREG-1:0]  w_wb_clr;
   logic [NREG-1:0]  w_busy;
   logic [NREG-1:0]  w_busy_eff;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_wb_err;

   logic             w_rs1_nz;
   logic             w_rs2_nz;
   logic             w_wr_nz;
   logic             w_hazard;
   logic             w_room;
   logic             w_ready;
   logic             w_set_en;

   rf_scoreboard #(
      .NREG    (NREG),
      .MAX_OUT (MAX_OUT)
   ) u_sb (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_set_en    (w_set_en),
      .i_set_rd    (i_issue_rd),
      .i_wb_valid  (i_wb_valid),
      .i_wb_rd     (i_wb_rd),
      .o_wb_clr    (w_wb_clr),
      .o_busy_mask (w_busy),
      .o_out_cnt   (w_cnt),
      .o_cnt_next  (w_cnt_next),
      .o_wb_err    (w_wb_err)
   );

   assign w_rs1_nz   = nz(i_issue_rs1);
   assign w_rs2_nz   = nz(i_issue_rs2);
   assign w_wr_nz    = i_issue_wr & nz(i_issue_rd);
   // A register retiring this cycle no longer blocks a consumer.
   assign w_busy_eff = w_busy & ~w_wb_clr;

   assign w_hazard = (i_issue_use_rs1 & w_rs1_nz & w_busy_eff[i_issue_rs1])
                   | (i_issue_use_rs2 & w_rs2_nz & w_busy_eff[i_issue_rs2])
                   | (w_wr_nz & w_busy_eff[i_issue_rd]);

   assign w_room  = w_cnt < CNT_W'(MAX_OUT);
   assign w_ready = ~i_reset & (r_state == RUN) & ~w_hazard
                  & (w_room | ~w_wr_nz);

   assign w_set_en = i_issue_valid & w_ready & w_wr_nz;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_flush_done = 1'b0;
      unique case (r_state)
         RUN: begin
            if (i_flush_req) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_cnt_next == '0) begin
               w_state_next = RUN;
               w_flush_done = 1'b1;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

   assign o_issue_ready = w_ready;
   assign o_flush_done  = w_flush_done & ~i_reset;

   assign o_fwd1 = i_issue_valid & i_issue_use_rs1 & w_rs1_nz
                 & w_wb_clr[i_issue_rs1];
   assign o_fwd2 = i_issue_valid & i_issue_use_rs2 & w_rs2_nz
                 & w_wb_clr[i_issue_rs2];

   assign o_rf_ra1 = i_issue_rs1;
   assign o_rf_ra2 = i_issue_rs2;
   assign o_rf_re1 = i_issue_valid & i_issue_use_rs1 & ~i_reset;
   assign o_rf_re2 = i_issue_valid & i_issue_use_rs2 & ~i_reset;

   assign o_rf_we    = i_wb_valid & nz(i_wb_rd) & ~i_reset;
   assign o_rf_wa    = i_wb_rd;
   assign o_rf_wdata = i_wb_data;

   assign o_busy_mask = w_busy;
   assign o_out_cnt   = w_cnt;
   assign o_wb_err    = w_wb_err;

endmodule
